// File: rtl/difftest_commit_queue.sv
// Multi-lane in-order commit staging FIFO feeding the difftest instruction-commit ports.
// Optional trap detection (instr 0x6b) is built when DIFFTEST_TRAP_EN is defined.
module difftest_commit_queue_chk #(
  parameter int NCH = 2
) (
  input logic           clock,
  input logic           reset,
  input logic [NCH-1:0] in_valid
);
  // producer lanes must be packed from lane 0 upward
  always @(posedge clock) begin
    if (!reset) begin
      assert ((in_valid & (in_valid + NCH'(1))) == '0)
        else $error("difftest_commit_queue: non-contiguous in_valid %b", in_valid);
    end
  end
endmodule

module difftest_commit_queue #(
  parameter int NCH     = 2,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 5000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*64-1:0]       in_pc,
  input  logic [NCH*32-1:0]       in_instr,
  input  logic [NCH-1:0]          in_wen,
  input  logic [NCH*8-1:0]        in_wdest,
  input  logic [NCH*64-1:0]       in_wdata,
  input  logic [NCH-1:0]          in_skip,
  output logic                    in_ready,
  input  logic                    drain_en,
  output logic [NCH-1:0]          out_valid,
  output logic [NCH*64-1:0]       out_pc,
  output logic [NCH*32-1:0]       out_instr,
  output logic [NCH-1:0]          out_wen,
  output logic [NCH*8-1:0]        out_wdest,
  output logic [NCH*64-1:0]       out_wdata,
  output logic [NCH-1:0]          out_skip,
  output logic [$clog2(DEPTH):0]  count,
  output logic [63:0]             instret,
  output logic [63:0]             cycle_cnt,
  output logic                    stall_flag
`ifdef DIFFTEST_TRAP_EN
  ,
  output logic                    trap_valid,
  output logic [63:0]             trap_pc,
  output logic [63:0]             trap_code,
  output logic [63:0]             trap_instret
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  function automatic logic [PW-1:0] popcnt(input logic [NCH-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < NCH; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  logic [63:0] r_pc_mem    [DEPTH];
  logic [31:0] r_instr_mem [DEPTH];
  logic        r_wen_mem   [DEPTH];
  logic [7:0]  r_wdest_mem [DEPTH];
  logic [63:0] r_wdata_mem [DEPTH];
  logic        r_skip_mem  [DEPTH];

  logic [PW-1:0]     r_wptr, r_rptr, r_count;
  logic [63:0]       r_instret, r_cycle;
  logic [WW-1:0]     r_wd;
  logic              r_stall;
  logic [NCH-1:0]    r_out_valid, r_out_wen, r_out_skip;
  logic [NCH*64-1:0] r_out_pc, r_out_wdata;
  logic [NCH*32-1:0] r_out_instr;
  logic [NCH*8-1:0]  r_out_wdest;

  logic [PW-1:0] w_free, w_n, w_m, w_commit;
  logic          w_ready, w_push, w_drain;
  logic [AW-1:0] w_rd_idx [NCH];
  logic [AW-1:0] w_wr_idx [NCH];

`ifdef DIFFTEST_TRAP_EN
  logic          r_trap_valid;
  logic [63:0]   r_trap_pc, r_trap_code, r_trap_instret;
  logic          w_trap_hit;
  logic [PW-1:0] w_trap_lane;
  logic [63:0]   w_trap_pc, w_trap_code;
`endif

  // Push/pop sizing; in_ready uses the pre-pop occupancy so it never overcommits
  always_comb begin
    w_free  = PW'(DEPTH) - r_count;
    w_ready = (w_free >= PW'(NCH));
    w_push  = w_ready && (in_valid != '0);
    w_n     = w_push ? popcnt(in_valid) : '0;
`ifdef DIFFTEST_TRAP_EN
    w_drain = drain_en && !r_trap_valid;
`else
    w_drain = drain_en;
`endif
    if (!w_drain) begin
      w_m = '0;
    end else if (r_count < PW'(NCH)) begin
      w_m = r_count;
    end else begin
      w_m = PW'(NCH);
    end
    for (int i = 0; i < NCH; i++) begin
      w_rd_idx[i] = r_rptr[AW-1:0] + AW'(i);
      w_wr_idx[i] = r_wptr[AW-1:0] + AW'(i);
    end
  end

`ifdef DIFFTEST_TRAP_EN
  // Lowest popped lane holding the trap opcode truncates this cycle's commit group
  always_comb begin
    w_trap_hit  = 1'b0;
    w_trap_lane = '0;
    w_trap_pc   = 64'd0;
    w_trap_code = 64'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((PW'(i) < w_m) && (r_instr_mem[w_rd_idx[i]] == 32'h0000_006b)) begin
        w_trap_hit  = 1'b1;
        w_trap_lane = PW'(i);
        w_trap_pc   = r_pc_mem[w_rd_idx[i]];
        w_trap_code = r_wdata_mem[w_rd_idx[i]];
      end else begin
        w_trap_hit  = w_trap_hit;
      end
    end
    w_commit = w_trap_hit ? (w_trap_lane + PW'(1)) : w_m;
  end

  // Sticky trap capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_trap_valid   <= 1'b0;
      r_trap_pc      <= 64'd0;
      r_trap_code    <= 64'd0;
      r_trap_instret <= 64'd0;
    end else if (w_trap_hit) begin
      r_trap_valid   <= 1'b1;
      r_trap_pc      <= w_trap_pc;
      r_trap_code    <= w_trap_code;
      r_trap_instret <= r_instret + 64'(w_commit);
    end
  end

  assign trap_valid   = r_trap_valid;
  assign trap_pc      = r_trap_pc;
  assign trap_code    = r_trap_code;
  assign trap_instret = r_trap_instret;
`else
  always_comb begin
    w_commit = w_m;
  end
`endif

  // Entry storage, written lane by lane in arrival order
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (w_push && in_valid[i]) begin
        r_pc_mem[w_wr_idx[i]]    <= in_pc[i*64 +: 64];
        r_instr_mem[w_wr_idx[i]] <= in_instr[i*32 +: 32];
        r_wen_mem[w_wr_idx[i]]   <= in_wen[i];
        r_wdest_mem[w_wr_idx[i]] <= in_wdest[i*8 +: 8];
        r_wdata_mem[w_wr_idx[i]] <= in_wdata[i*64 +: 64];
        r_skip_mem[w_wr_idx[i]]  <= in_skip[i];
      end
    end
  end

  // Pointers, counters, registered output lanes and watchdog
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_instret   <= 64'd0;
      r_cycle     <= 64'd0;
      r_wd        <= '0;
      r_stall     <= 1'b0;
      r_out_valid <= '0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_wen   <= '0;
      r_out_wdest <= '0;
      r_out_wdata <= '0;
      r_out_skip  <= '0;
    end else begin
      r_wptr    <= r_wptr + w_n;
      r_rptr    <= r_rptr + w_m;
      r_count   <= r_count + w_n - w_m;
      r_instret <= r_instret + 64'(w_commit);
      r_cycle   <= r_cycle + 64'd1;
      for (int i = 0; i < NCH; i++) begin
        r_out_valid[i] <= (PW'(i) < w_commit);
        // idle lanes keep their last payload
        if (PW'(i) < w_commit) begin
          r_out_pc[i*64 +: 64]    <= r_pc_mem[w_rd_idx[i]];
          r_out_instr[i*32 +: 32] <= r_instr_mem[w_rd_idx[i]];
          r_out_wen[i]            <= r_wen_mem[w_rd_idx[i]];
          r_out_wdest[i*8 +: 8]   <= r_wdest_mem[w_rd_idx[i]];
          r_out_wdata[i*64 +: 64] <= r_wdata_mem[w_rd_idx[i]];
          r_out_skip[i]           <= r_skip_mem[w_rd_idx[i]];
        end
      end
      if (w_m != '0) begin
        r_wd <= '0;
      end else if (r_wd != WW'(TIMEOUT)) begin
        r_wd <= r_wd + WW'(1);
      end
      if ((TIMEOUT != 0) && (w_m == '0) && (r_wd == WW'(TIMEOUT - 1))) begin
        r_stall <= 1'b1;
      end
    end
  end

  difftest_commit_queue_chk #(.NCH(NCH)) u_chk (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid)
  );

  assign in_ready   = w_ready;
  assign out_valid  = r_out_valid;
  assign out_pc     = r_out_pc;
  assign out_instr  = r_out_instr;
  assign out_wen    = r_out_wen;
  assign out_wdest  = r_out_wdest;
  assign out_wdata  = r_out_wdata;
  assign out_skip   = r_out_skip;
  assign count      = r_count;
  assign instret    = r_instret;
  assign cycle_cnt  = r_cycle;
  assign stall_flag = r_stall;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Randomised and directed bench for difftest_commit_queue against a queue-based reference model.
module tb_difftest_commit_queue;
  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int TO    = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    in_valid, in_wen, in_skip, in_ready_unused;
  logic [127:0]  in_pc, in_wdata;
  logic [63:0]   in_instr;
  logic [15:0]   in_wdest;
  logic          in_ready, drain_en;
  logic [1:0]    out_valid, out_wen, out_skip;
  logic [127:0]  out_pc, out_wdata;
  logic [63:0]   out_instr;
  logic [15:0]   out_wdest;
  logic [3:0]    count;
  logic [63:0]   instret, cycle_cnt;
  logic          stall_flag;
`ifdef DIFFTEST_TRAP_EN
  logic          trap_valid;
  logic [63:0]   trap_pc, trap_code, trap_instret;
`endif

  difftest_commit_queue #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_wen(in_wen),
    .in_wdest(in_wdest), .in_wdata(in_wdata), .in_skip(in_skip), .in_ready(in_ready),
    .drain_en(drain_en),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_wen(out_wen),
    .out_wdest(out_wdest), .out_wdata(out_wdata), .out_skip(out_skip),
    .count(count), .instret(instret), .cycle_cnt(cycle_cnt), .stall_flag(stall_flag)
`ifdef DIFFTEST_TRAP_EN
    , .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_code(trap_code),
    .trap_instret(trap_instret)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        skip;
  } ent_t;

  ent_t            q[$];
  ent_t            eo[NCH];
  logic [1:0]      e_ov;
  longint unsigned e_inst, e_cyc;
  int              idle;
  logic            e_stall;
  int              total = 0;
  int              bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NCH; i++) eo[i] = '{default: 0};
    e_ov = 2'b00; e_inst = 0; e_cyc = 0; idle = 0; e_stall = 1'b0;
  endtask

  // One clock of the reference: pop up to NCH old entries, then accept a full group if room
  task automatic model_step();
    int   qs;
    int   m;
    bit   rdy;
    ent_t e;
    qs  = q.size();
    rdy = (DEPTH - qs) >= NCH;
    m   = drain_en ? ((qs < NCH) ? qs : NCH) : 0;
    for (int i = 0; i < NCH; i++) begin
      if (i < m) begin eo[i] = q.pop_front(); e_ov[i] = 1'b1; end
      else e_ov[i] = 1'b0;
    end
    e_inst += 64'(m);
    e_cyc  += 1;
    if (m > 0) idle = 0;
    else begin
      idle++;
      if (idle >= TO) e_stall = 1'b1;
    end
    if (rdy) begin
      for (int i = 0; i < NCH; i++) begin
        if (in_valid[i]) begin
          e.pc = in_pc[i*64 +: 64]; e.instr = in_instr[i*32 +: 32]; e.wen = in_wen[i];
          e.wdest = in_wdest[i*8 +: 8]; e.wdata = in_wdata[i*64 +: 64]; e.skip = in_skip[i];
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'((DEPTH - q.size()) >= NCH));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    for (int i = 0; i < NCH; i++) begin
      chk("out_pc", out_pc[i*64 +: 64], eo[i].pc);
      chk("out_instr", 64'(out_instr[i*32 +: 32]), 64'(eo[i].instr));
      chk("out_wen", 64'(out_wen[i]), 64'(eo[i].wen));
      chk("out_wdest", 64'(out_wdest[i*8 +: 8]), 64'(eo[i].wdest));
      chk("out_wdata", out_wdata[i*64 +: 64], eo[i].wdata);
      chk("out_skip", 64'(out_skip[i]), 64'(eo[i].skip));
    end
    chk("instret", instret, e_inst);
    chk("cycle_cnt", cycle_cnt, e_cyc);
    chk("stall_flag", 64'(stall_flag), 64'(e_stall));
  endtask

  task automatic set_in(input logic [1:0] v, input logic [63:0] pc, input logic dr);
    in_valid = v;
    in_pc    = {pc + 64'd4, pc};
    in_instr = {32'h0000_0013, 32'h0000_0013};
    in_wen   = 2'($urandom);
    in_wdest = 16'($urandom);
    in_wdata = {$urandom, $urandom, $urandom, $urandom};
    in_skip  = 2'($urandom);
    drain_en = dr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    set_in(2'b00, 64'd0, 1'b0);
    #2;
    do_reset();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_count", 64'(count), 64'd0);

    // single commit
    set_in(2'b01, 64'h8000_0000, 1'b1);
    tick();
    chk("single_count", 64'(count), 64'd1);
    chk("single_early", 64'(out_valid), 64'd0);
    set_in(2'b00, 64'd0, 1'b1);
    tick();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_pc", out_pc[63:0], 64'h8000_0000);
    chk("single_instret", instret, 64'd1);
    tick();
    chk("single_pulse", 64'(out_valid), 64'd0);

    // full FIFO
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 64'h8000_0000 + 64'(8 * k), 1'b0);
      tick();
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(in_ready), 64'd0);
    set_in(2'b11, 64'h9000_0000, 1'b0);
    tick();
    chk("full_ignored", 64'(count), 64'd8);
    for (int k = 0; k < 4; k++) begin
      set_in(2'b00, 64'd0, 1'b1);
      tick();
      chk("full_drain_valid", 64'(out_valid), 64'd3);
      chk("full_drain_pc0", out_pc[63:0], 64'h8000_0000 + 64'(8 * k));
      chk("full_drain_pc1", out_pc[127:64], 64'h8000_0004 + 64'(8 * k));
    end
    chk("full_empty", 64'(count), 64'd0);

    // odd count and pointer wrap
    do_reset();
    set_in(2'b11, 64'hA000_0000, 1'b0); tick();
    set_in(2'b01, 64'hA000_0008, 1'b0); tick();
    set_in(2'b00, 64'd0, 1'b1); tick();
    chk("odd_first", 64'(out_valid), 64'd3);
    tick();
    chk("odd_second", 64'(out_valid), 64'd1);
    chk("odd_pc", out_pc[63:0], 64'hA000_0008);
    for (int k = 0; k < 4; k++) begin
      set_in((k == 3) ? 2'b01 : 2'b11, 64'hB000_0000 + 64'(8 * k), 1'b0);
      tick();
    end
    chk("wrap_count", 64'(count), 64'd7);
    for (int k = 0; k < 4; k++) begin
      set_in(2'b00, 64'd0, 1'b1);
      tick();
      chk("wrap_valid", 64'(out_valid), (k == 3) ? 64'd1 : 64'd3);
      chk("wrap_pc", out_pc[63:0], 64'hB000_0000 + 64'(8 * k));
    end
    chk("wrap_instret", instret, 64'd10);

    // reset mid-operation
    set_in(2'b11, 64'hC000_0000, 1'b0); tick();
    set_in(2'b11, 64'hC000_0008, 1'b0); tick();
    set_in(2'b01, 64'hC000_0010, 1'b0); tick();
    chk("midrst_before", 64'(count), 64'd5);
    do_reset();
    chk("midrst_instret", instret, 64'd0);
    for (int k = 0; k < 3; k++) begin
      set_in(2'b00, 64'd0, 1'b1);
      tick();
      chk("midrst_stale", 64'(out_valid), 64'd0);
    end

    // watchdog
    do_reset();
    set_in(2'b00, 64'd0, 1'b1);
    for (int k = 0; k < TO - 1; k++) tick();
    chk("wd_not_yet", 64'(stall_flag), 64'd0);
    tick();
    chk("wd_fires", 64'(stall_flag), 64'd1);
    do_reset();
    for (int k = 0; k < 10; k++) tick();
    set_in(2'b01, 64'hD000_0000, 1'b1); tick();
    set_in(2'b00, 64'd0, 1'b1);
    for (int k = 0; k < 16; k++) tick();
    chk("wd_kept_low", 64'(stall_flag), 64'd0);

    // randomised traffic with periodic drain stalls
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int r;
      logic [1:0] v;
      logic dr;
      r  = int'($urandom_range(0, 2));
      v  = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      dr = ((c % 100) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      set_in(v, {32'h8000_0000, $urandom}, dr);
      tick();
      if (c == 350) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/difftest_commit_queue.md
Name: difftest_commit_queue

Overview:
- Parametrised, multi-lane commit staging buffer between the core's retire stage and the difftest instruction-commit ports in SimTop.
- Accepts up to NCH retired instructions per cycle and stores them in order in a DEPTH-entry FIFO.
- Emits up to NCH commits per cycle, packed into the low output lanes, with register write-back info, instret/cycle counters and a commit watchdog.
- Replaces the single-lane `r_pc`/`r_inst`/`r_valid` commit register.

Parameters:
- NCH, 2, number of input and output commit lanes (1..4).
- DEPTH, 8, FIFO entries; power of two, >= 2*NCH.
- TIMEOUT, 5000, cycles without a dequeue before `stall_flag` sets; 0 disables the watchdog.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  lane valids; set lanes must be contiguous from lane 0.
- in_pc  in  NCH*64  per-lane PC; lane i occupies bits [64i+63:64i].
- in_instr  in  NCH*32  per-lane instruction.
- in_wen  in  NCH  per-lane GPR write enable.
- in_wdest  in  NCH*8  per-lane destination register index.
- in_wdata  in  NCH*64  per-lane write-back data.
- in_skip  in  NCH  per-lane difftest skip (MMIO access).
- in_ready  out  1  high when free entries >= NCH.
- drain_en  in  1  allows dequeue this cycle.
- out_valid  out  NCH  output lane valids, contiguous from lane 0.
- out_pc, out_instr, out_wen, out_wdest, out_wdata, out_skip  out  same widths as inputs  committed entry fields.
- count  out  clog2(DEPTH)+1  current occupancy.
- instret  out  64  total dequeued entries.
- cycle_cnt  out  64  cycles since reset.
- stall_flag  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, active-high):
  - pointers, `count`, `instret`, `cycle_cnt`, watchdog counter and `stall_flag` clear to 0.
  - all `out_*` registers clear to 0.
  - `in_ready` reads 1 as soon as reset deasserts.
  - Reset asserted mid-operation discards all queued entries; nothing is flushed out.
- Storage: circular FIFO with write/read pointers of clog2(DEPTH)+1 bits; pointers wrap naturally modulo DEPTH.
- Enqueue:
  - Fires when `in_ready` is high and `in_valid` is non-zero.
  - All-or-none: push n = popcount(`in_valid`) entries in lane order (lane 0 is the oldest).
  - `in_valid` presented while `in_ready` is low is ignored; the producer must hold it.
  - A non-contiguous `in_valid` is illegal; behaviour is undefined, and an assertion in simulation flags it.
- Dequeue:
  - m = drain_en ? min(count, NCH) : 0.
  - Output is registered: entries popped in cycle t appear on `out_*` in cycle t+1.
  - out_valid[i] = 1 for i < m; lanes i >= m have valid 0, and their data holds its previous value.
  - `out_valid` is a single-cycle pulse per commit.
  - Minimum latency from enqueue to `out_valid` is 2 cycles: write in t, visible in `count` at t+1, output at t+2.
- Simultaneous push and pop:
  - `in_ready` is computed from `count` before this cycle's pop (conservative).
  - count_next = count + n - m.
  - Full condition: free < NCH forces `in_ready` to 0.
  - Empty condition: `count` = 0 forces m = 0.
- `instret`: adds m each cycle. Wraps at 2^64 with no saturation.
- `cycle_cnt`: increments every cycle after reset.
- Watchdog:
  - Counter resets to 0 on any cycle with m > 0; otherwise it increments.
  - When the counter reaches TIMEOUT, `stall_flag` sets and stays set until reset.
  - With TIMEOUT = 0 the watchdog is disabled and `stall_flag` stays 0.

Optional Feature:
- Macro: DIFFTEST_TRAP_EN.
- When defined:
  - Adds outputs `trap_valid` (1), `trap_pc` (64), `trap_code` (64) and `trap_instret` (64).
  - When a dequeued entry has instr == 32'h0000006b, the lowest such lane is the trap lane.
  - On the trap, `trap_valid` sets sticky and the other three outputs capture that lane's `pc`, its `wdata` (the a0 value supplied by the core) and the post-update `instret`.
  - Lanes above the trap lane are dropped (out_valid = 0).
  - All further dequeues are suppressed until reset.
- When undefined: none of these ports or logic exist, and 0x6b is treated as an ordinary entry.

Test Plan (NCH=2, DEPTH=8):
- Single commit: reset, then one cycle of in_valid=2'b01, pc=0x80000000, instr=0x00000013, drain_en=1 -> two cycles later out_valid=2'b01, out_pc=0x80000000 for exactly one cycle; instret=1.
- Full FIFO: drain_en=0, push 2'b11 four times (pc 0x80000000..0x8000001c) -> count=8 and in_ready=0. A 5th push is ignored. Raise drain_en -> four cycles of out_valid=2'b11 in PC order; count returns to 0.
- Odd count and wrap-around: push 3 entries, drain, then push 7 entries so pointers wrap -> outputs 2'b11, 2'b11, 2'b11, 2'b01 in order; instret=10.
- Reset mid-operation: assert reset with count=5 -> count=0, out_valid=0 and instret=0 immediately; no stale output after reset is released.
- Watchdog: TIMEOUT=20, no pushes -> stall_flag rises after 20 idle cycles. A commit before cycle 20 keeps it 0.
- Trap (DIFFTEST_TRAP_EN): push lane0 pc=0x80000100 instr=0x6b wdata=0, lane1 valid -> trap_valid=1, trap_pc=0x80000100, trap_code=0; lane1 is not emitted; later pushes produce no out_valid.
